hazard_stall_ctrl: RTL and testbench

- Pipeline interlock controller for the 5-stage core.
- Decodes which source registers the D-stage instruction reads, using the same opcode set as the rs-read decoder.
- Detects load-use hazards against the X-stage lw and sequences the shared multdiv unit: start pulse, busy freeze, completion.
- Drives the F/D hold, D/X bubble, X freeze and X/M bubble controls; sits beside the D/X pipeline latch.

---
 rtl/hazard_stall_ctrl.sv | 169 ++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline interlock controller for the 5-stage core.
// Detects load-use hazards between the D-stage instruction and an X-stage lw,
// and sequences the shared multdiv unit (start pulse, busy freeze, completion).
// Optional build macro HAZARD_PERF_EN adds saturating stall counters
// lu_stall_cnt and md_stall_cnt.
module hazard_stall_ctrl #(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] opcode_d,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [4:0] rd_d,
    input  logic [4:0] opcode_x,
    input  logic [4:0] aluop_x,
    input  logic [4:0] rd_x,
    input  logic       valid_x,
    input  logic       md_ready,
    input  logic       md_exception,
    output logic       stall_fd,
    output logic       bubble_dx,
    output logic       freeze_x,
    output logic       bubble_xm,
    output logic       ctrl_mult,
    output logic       ctrl_div,
    output logic       md_busy,
    output logic       md_timeout,
    output logic       md_exc_out
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0] lu_stall_cnt,
    output logic [15:0] md_stall_cnt
`endif
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] ALU_MULT = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, BUSY, DONE} md_state_t;

    md_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             frz;
    logic             out_en;
    logic             reads_a;
    logic             reads_b;
    logic [4:0]       src_a;
    logic [4:0]       src_b;
    logic             hz;
    logic             is_md;
    logic             lu_stall;

    // Decode which source registers the D-stage instruction actually reads
    always_comb begin
        reads_a = 1'b0;
        reads_b = 1'b0;
        src_a   = rs_d;
        src_b   = (opcode_d == OP_RTYPE) ? rt_d : rd_d;
        case (opcode_d)
            5'b00000, 5'b00111, 5'b00010, 5'b00110: begin
                reads_a = 1'b1;
                reads_b = 1'b1;
            end
            5'b00101, 5'b01000: reads_a = 1'b1;
            5'b00100:           reads_b = 1'b1;
            default: begin
                reads_a = 1'b0;
                reads_b = 1'b0;
            end
        endcase
    end

    // Load-use hazard and multdiv-request detection against the X stage
    always_comb begin
        hz = valid_x && (opcode_x == OP_LW) && (rd_x != 5'd0) &&
             ((reads_a && (src_a == rd_x)) || (reads_b && (src_b == rd_x)));
        is_md = valid_x && (opcode_x == OP_RTYPE) &&
                ((aluop_x == ALU_MULT) || (aluop_x == ALU_DIV));
    end

    // Outputs stay quiet for the first cycle after reset release
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) out_en <= 1'b0;
        else        out_en <= 1'b1;
    end

    // Multdiv sequencer: start pulse, busy freeze with timeout, one-cycle done
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            frz        <= 1'b0;
            ctrl_mult  <= 1'b0;
            ctrl_div   <= 1'b0;
            md_timeout <= 1'b0;
            md_exc_out <= 1'b0;
        end else begin
            ctrl_mult  <= 1'b0;
            ctrl_div   <= 1'b0;
            md_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (is_md) begin
                        state     <= START;
                        cnt       <= '0;
                        frz       <= 1'b1;
                        ctrl_mult <= (aluop_x == ALU_MULT);
                        ctrl_div  <= (aluop_x == ALU_DIV);
                    end
                end
                START: begin
                    state <= BUSY;
                    cnt   <= '0;
                end
                BUSY: begin
                    if (md_ready) begin
                        state <= DONE;
                        frz   <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state      <= IDLE;
                        frz        <= 1'b0;
                        md_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    md_exc_out <= md_exception;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    frz   <= 1'b0;
                end
            endcase
        end
    end

    // Pipeline controls: freeze wins over load-use since the D/X latch holds
    always_comb begin
        lu_stall  = out_en && hz && !frz;
        freeze_x  = out_en && frz;
        bubble_xm = out_en && frz;
        stall_fd  = freeze_x || lu_stall;
        bubble_dx = lu_stall;
        md_busy   = frz;
    end

`ifdef HAZARD_PERF_EN
    // Saturating counters of load-use stall cycles and multdiv freeze cycles
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lu_stall_cnt <= 16'h0000;
            md_stall_cnt <= 16'h0000;
        end else begin
            if (lu_stall && (lu_stall_cnt != 16'hFFFF))
                lu_stall_cnt <= lu_stall_cnt + 16'd1;
            if (freeze_x && (md_stall_cnt != 16'hFFFF))
                md_stall_cnt <= md_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed vectors with hand-computed expected outputs,
// pushed into a scoreboard queue and checked by a separate monitor process.
module tb_hazard_stall_ctrl;

    logic       clock;
    logic       reset;
    logic [4:0] opcode_d, rs_d, rt_d, rd_d;
    logic [4:0] opcode_x, aluop_x, rd_x;
    logic       valid_x, md_ready, md_exception;
    logic       stall_fd, bubble_dx, freeze_x, bubble_xm;
    logic       ctrl_mult, ctrl_div, md_busy, md_timeout, md_exc_out;
`ifdef HAZARD_PERF_EN
    logic [15:0] lu_stall_cnt, md_stall_cnt;
`endif

    hazard_stall_ctrl #(.MD_TIMEOUT(40), .CNT_W(6)) dut (
        .clock        (clock),
        .reset        (reset),
        .opcode_d     (opcode_d),
        .rs_d         (rs_d),
        .rt_d         (rt_d),
        .rd_d         (rd_d),
        .opcode_x     (opcode_x),
        .aluop_x      (aluop_x),
        .rd_x         (rd_x),
        .valid_x      (valid_x),
        .md_ready     (md_ready),
        .md_exception (md_exception),
        .stall_fd     (stall_fd),
        .bubble_dx    (bubble_dx),
        .freeze_x     (freeze_x),
        .bubble_xm    (bubble_xm),
        .ctrl_mult    (ctrl_mult),
        .ctrl_div     (ctrl_div),
        .md_busy      (md_busy),
        .md_timeout   (md_timeout),
        .md_exc_out   (md_exc_out)
`ifdef HAZARD_PERF_EN
        ,
        .lu_stall_cnt (lu_stall_cnt),
        .md_stall_cnt (md_stall_cnt)
`endif
    );

    // Output vector order: stall_fd bubble_dx freeze_x bubble_xm ctrl_mult ctrl_div md_busy md_timeout md_exc_out
    localparam logic [8:0] E0   = 9'b000000000;
    localparam logic [8:0] LU   = 9'b110000000;
    localparam logic [8:0] FRZ  = 9'b101100100;
    localparam logic [8:0] SMUL = 9'b101110100;
    localparam logic [8:0] SDIV = 9'b101101100;
    localparam logic [8:0] TMO  = 9'b000000010;
    localparam logic [8:0] EXC  = 9'b000000001;

    localparam logic [4:0] OP_R  = 5'b00000;
    localparam logic [4:0] OP_J  = 5'b00001;
    localparam logic [4:0] OP_LW = 5'b01000;
    localparam logic [4:0] OP_SW = 5'b00111;
    localparam logic [4:0] OP_B4 = 5'b00100;
    localparam logic [4:0] A_MUL = 5'b00110;
    localparam logic [4:0] A_DIV = 5'b00111;

    typedef struct {
        string      name;
        logic [8:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_compared;
    int   n_mismatched;

    logic [8:0] act;
    assign act = {stall_fd, bubble_dx, freeze_x, bubble_xm, ctrl_mult,
                  ctrl_div, md_busy, md_timeout, md_exc_out};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle of inputs just after the clock edge and queue the expected outputs
    task automatic applyStimulus(input string name,
                                 input logic [4:0] od, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [4:0] rd,
                                 input logic [4:0] ox, input logic [4:0] alu,
                                 input logic [4:0] rdx, input logic vx,
                                 input logic rdy, input logic exc,
                                 input logic rst, input logic [8:0] exp);
        exp_t e;
        @(posedge clock);
        #1;
        opcode_d     = od;
        rs_d         = rs;
        rt_d         = rt;
        rd_d         = rd;
        opcode_x     = ox;
        aluop_x      = alu;
        rd_x         = rdx;
        valid_x      = vx;
        md_ready     = rdy;
        md_exception = exc;
        reset        = rst;
        e.name       = name;
        e.exp        = exp;
        sb.push_back(e);
    endtask

    // Pop the oldest expectation and compare against the DUT outputs
    task automatic checkOutput();
        exp_t e;
        e = sb.pop_front();
        n_compared++;
        if (act !== e.exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", e.name, act, e.exp, $time);
        end
    endtask

    // Monitor samples on the falling edge, away from the active edge
    initial begin
        forever begin
            @(negedge clock);
            if (sb.size() > 0) checkOutput();
        end
    end

    // Watchdog so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset        = 1'b0;
        opcode_d = OP_R; rs_d = 5'd5; rt_d = 5'd0; rd_d = 5'd0;
        opcode_x = OP_LW; aluop_x = 5'd0; rd_x = 5'd5;
        valid_x = 1'b1; md_ready = 1'b0; md_exception = 1'b0;

        // Reset held with a live hazard on the inputs, then the quiet first cycle
        applyStimulus("reset0", OP_R, 5, 0, 0, OP_LW, 0, 5, 1, 0, 0, 0, E0);
        applyStimulus("reset1", OP_R, 5, 0, 0, OP_LW, 0, 5, 1, 0, 0, 0, E0);
        applyStimulus("first_cycle", OP_R, 5, 0, 0, OP_LW, 0, 5, 1, 0, 0, 1, E0);

        // Load-use decode cases
        applyStimulus("lu_rs", OP_R, 5, 0, 0, OP_LW, 0, 5, 1, 0, 0, 1, LU);
        applyStimulus("lu_clear", OP_R, 5, 0, 0, OP_R, 0, 5, 1, 0, 0, 1, E0);
        applyStimulus("lu_rdx0", OP_R, 0, 0, 0, OP_LW, 0, 0, 1, 0, 0, 1, E0);
        applyStimulus("lu_jump", OP_J, 5, 5, 5, OP_LW, 0, 5, 1, 0, 0, 1, E0);
        applyStimulus("lu_sw_rd", OP_SW, 1, 0, 5, OP_LW, 0, 5, 1, 0, 0, 1, LU);
        applyStimulus("lu_r_rt", OP_R, 1, 5, 0, OP_LW, 0, 5, 1, 0, 0, 1, LU);
        applyStimulus("lu_r_rd_unread", OP_R, 1, 2, 5, OP_LW, 0, 5, 1, 0, 0, 1, E0);
        applyStimulus("lu_invalid_x", OP_R, 5, 0, 0, OP_LW, 0, 5, 0, 0, 0, 1, E0);
        applyStimulus("lu_b4_rs_only", OP_B4, 5, 0, 1, OP_LW, 0, 5, 1, 0, 0, 1, E0);
        applyStimulus("lu_b4_rd", OP_B4, 1, 0, 5, OP_LW, 0, 5, 1, 0, 0, 1, LU);

        // Multiply completing after 32 busy cycles
        applyStimulus("mul_idle", OP_J, 0, 0, 0, OP_R, A_MUL, 3, 1, 0, 0, 1, E0);
        applyStimulus("mul_start", OP_J, 0, 0, 0, OP_R, A_MUL, 3, 1, 0, 0, 1, SMUL);
        for (int i = 1; i <= 31; i++)
            applyStimulus("mul_busy", OP_J, 0, 0, 0, OP_R, A_MUL, 3, 1, 0, 0, 1, FRZ);
        applyStimulus("mul_busy_ready", OP_J, 0, 0, 0, OP_R, A_MUL, 3, 1, 1, 0, 1, FRZ);
        applyStimulus("mul_done", OP_J, 0, 0, 0, OP_R, 0, 0, 0, 0, 0, 1, E0);
        applyStimulus("mul_after", OP_J, 0, 0, 0, OP_R, A_MUL, 3, 1, 0, 0, 1, E0);
        applyStimulus("mul_restart", OP_J, 0, 0, 0, OP_R, 0, 0, 0, 0, 0, 1, SMUL);
        for (int i = 1; i <= 3; i++)
            applyStimulus("mul2_busy", OP_J, 0, 0, 0, OP_R, 0, 0, 0, 0, 0, 1, FRZ);
        applyStimulus("mul2_ready", OP_J, 0, 0, 0, OP_R, 0, 0, 0, 1, 0, 1, FRZ);
        applyStimulus("mul2_done", OP_J, 0, 0, 0, OP_R, 0, 0, 0, 0, 0, 1, E0);

        // Divide that never completes, with a load-use overlap during busy
        applyStimulus("div_idle", OP_J, 0, 0, 0, OP_R, A_DIV, 4, 1, 0, 0, 1, E0);
        applyStimulus("div_start", OP_J, 0, 0, 0, OP_R, A_DIV, 4, 1, 0, 0, 1, SDIV);
        for (int i = 1; i <= 40; i++) begin
            if (i == 10 || i == 11)
                applyStimulus("overlap", OP_R, 5, 0, 0, OP_LW, 0, 5, 1, 0, 0, 1, FRZ);
            else
                applyStimulus("div_busy", OP_J, 0, 0, 0, OP_R, A_DIV, 4, 1, 0, 0, 1, FRZ);
        end
        applyStimulus("div_timeout", OP_J, 0, 0, 0, OP_R, 0, 0, 0, 0, 0, 1, TMO);
        applyStimulus("div_after", OP_J, 0, 0, 0, OP_R, 0, 0, 0, 0, 0, 1, E0);

        // Divide completing with an exception
        applyStimulus("exc_idle", OP_J, 0, 0, 0, OP_R, A_DIV, 4, 1, 0, 0, 1, E0);
        applyStimulus("exc_start", OP_J, 0, 0, 0, OP_R, A_DIV, 4, 1, 0, 0, 1, SDIV);
        applyStimulus("exc_busy", OP_J, 0, 0, 0, OP_R, A_DIV, 4, 1, 0, 0, 1, FRZ);
        applyStimulus("exc_busy", OP_J, 0, 0, 0, OP_R, A_DIV, 4, 1, 0, 0, 1, FRZ);
        applyStimulus("exc_ready", OP_J, 0, 0, 0, OP_R, A_DIV, 4, 1, 1, 1, 1, FRZ);
        applyStimulus("exc_done", OP_J, 0, 0, 0, OP_R, 0, 0, 0, 0, 1, 1, E0);
        applyStimulus("exc_out", OP_J, 0, 0, 0, OP_R, 0, 0, 0, 0, 0, 1, EXC);

        // Reset asserted in busy cycle 10 of a multiply
        applyStimulus("rst_idle", OP_J, 0, 0, 0, OP_R, A_MUL, 3, 1, 0, 0, 1, EXC);
        applyStimulus("rst_start", OP_J, 0, 0, 0, OP_R, A_MUL, 3, 1, 0, 0, 1, SMUL | EXC);
        for (int i = 1; i <= 9; i++)
            applyStimulus("rst_busy", OP_J, 0, 0, 0, OP_R, A_MUL, 3, 1, 0, 0, 1, FRZ | EXC);
        applyStimulus("rst_async", OP_J, 0, 0, 0, OP_R, A_MUL, 3, 1, 0, 0, 0, E0);
        applyStimulus("rst_hold", OP_J, 0, 0, 0, OP_R, 0, 0, 0, 0, 0, 0, E0);
        applyStimulus("rst_release", OP_J, 0, 0, 0, OP_R, 0, 0, 0, 0, 0, 1, E0);
        applyStimulus("rst_idle_after", OP_J, 0, 0, 0, OP_R, 0, 0, 0, 0, 0, 1, E0);
        applyStimulus("rst_lu_after", OP_R, 5, 0, 0, OP_LW, 0, 5, 1, 0, 0, 1, LU);

        @(posedge clock);
        #1;
        if (sb.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
